// File: rtl/wait_generator.sv
// rtl/wait_generator.sv - Z80 wait-state generator: per-cycle-type internal waits merged with maskable external waits.
module wait_generator #(
    parameter int M1_WAITS     = 1,
    parameter int MEM_WAITS    = 0,
    parameter int IO_WAITS     = 1,
    parameter int EXT_CHANNELS = 2,
    parameter int CNT_W        = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    nm1,
    input  logic                    nmreq,
    input  logic                    niorq,
    input  logic                    nrd,
    input  logic                    nwr,
    input  logic                    wait_en,
    input  logic [EXT_CHANNELS-1:0] nextwait,
    input  logic [EXT_CHANNELS-1:0] ext_en,
    output logic                    nwait,
    output logic                    busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] M1_N  = CNT_W'(M1_WAITS);
    localparam logic [CNT_W-1:0] MEM_N = CNT_W'(MEM_WAITS);
    localparam logic [CNT_W-1:0] IO_N  = CNT_W'(IO_WAITS);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             strobe_q, strobe_d;
    logic             nwait_q, nwait_d;
    logic             busy_q, busy_d;

    logic             is_m1, is_mem, is_io, start;
    logic             iwait, ewait;
    logic [CNT_W-1:0] n_sel;

    always_comb begin
        is_m1    = !nm1 && !nmreq;
        is_mem   = nm1 && !nmreq && (!nrd || !nwr);
        is_io    = nm1 && !niorq && (!nrd || !nwr);
        strobe_d = !nmreq || !niorq;
        // Only the leading edge of a bus cycle may start a count.
        start    = (is_m1 || is_mem || is_io) && !strobe_q;

        n_sel = '0;
        if (is_m1)       n_sel = M1_N;
        else if (is_mem) n_sel = MEM_N;
        else if (is_io)  n_sel = IO_N;

        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (wait_en && (n_sel != '0)) begin
                        state_d = COUNT;
                        cnt_d   = n_sel;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            COUNT: begin
                // Abort takes priority over reaching the terminal count.
                if (!strobe_d) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = (cnt_q != '0) ? cnt_q - 1'b1 : '0;
                    if (cnt_q <= CNT_W'(1)) state_d = DONE;
                end
            end
            DONE: begin
                if (!strobe_d) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        iwait   = (state_d == COUNT);
        ewait   = |(~nextwait & ext_en);
        nwait_d = !(iwait || ewait);
        busy_d  = iwait;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            strobe_q <= 1'b0;
            nwait_q  <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            strobe_q <= strobe_d;
            nwait_q  <= nwait_d;
            busy_q   <= busy_d;
        end
    end

    assign nwait = nwait_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_wait_generator.sv
// tb/tb_wait_generator.sv - self-checking bench for wait_generator with two parameter sets.
module tb_wait_generator;

    logic       clk = 1'b0;
    logic       reset, nm1, nmreq, niorq, nrd, nwr, wait_en;
    logic [1:0] nextwait, ext_en;
    logic       nwait0, busy0, nwait1, busy1;

    int tests = 0;
    int fails = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    wait_generator #(.M1_WAITS(1), .MEM_WAITS(0), .IO_WAITS(3), .EXT_CHANNELS(2), .CNT_W(3)) dut0 (
        .clk(clk), .reset(reset), .nm1(nm1), .nmreq(nmreq), .niorq(niorq), .nrd(nrd), .nwr(nwr),
        .wait_en(wait_en), .nextwait(nextwait), .ext_en(ext_en), .nwait(nwait0), .busy(busy0));

    wait_generator #(.M1_WAITS(2), .MEM_WAITS(2), .IO_WAITS(7), .EXT_CHANNELS(2), .CNT_W(3)) dut1 (
        .clk(clk), .reset(reset), .nm1(nm1), .nmreq(nmreq), .niorq(niorq), .nrd(nrd), .nwr(nwr),
        .wait_en(wait_en), .nextwait(nextwait), .ext_en(ext_en), .nwait(nwait1), .busy(busy1));

    // Model: remaining wait clocks per instance plus an in-bus-cycle flag.
    int m1w [2] = '{1, 2};
    int memw[2] = '{0, 2};
    int iow [2] = '{3, 7};
    int rem [2] = '{0, 0};
    bit incyc[2] = '{1'b0, 1'b0};
    bit prev = 1'b0;
    bit exp_nw[2] = '{1'b1, 1'b1};
    bit exp_bz[2] = '{1'b0, 1'b0};

    task automatic model_step();
        bit strobe, c_m1, c_mem, c_io, ew;
        int n;
        strobe = !nmreq || !niorq;
        c_m1   = !nm1 && !nmreq;
        c_mem  = nm1 && !nmreq && (!nrd || !nwr);
        c_io   = nm1 && !niorq && (!nrd || !nwr);
        ew     = |(~nextwait & ext_en);
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                rem[i] = 0;
                incyc[i] = 1'b0;
            end else if (rem[i] > 0) begin
                if (!strobe) begin
                    rem[i] = 0;
                    incyc[i] = 1'b0;
                end else begin
                    rem[i] = rem[i] - 1;
                end
            end else if (incyc[i]) begin
                if (!strobe) incyc[i] = 1'b0;
            end else if ((c_m1 || c_mem || c_io) && !prev) begin
                incyc[i] = 1'b1;
                n = c_m1 ? m1w[i] : (c_mem ? memw[i] : iow[i]);
                rem[i] = wait_en ? n : 0;
            end
            exp_bz[i] = (rem[i] > 0);
            exp_nw[i] = reset ? 1'b1 : !((rem[i] > 0) || ew);
        end
        prev = reset ? 1'b0 : strobe;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    task automatic chk(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("cmp_nwait0", nwait0, exp_nw[0]);
            chk("cmp_busy0",  busy0,  exp_bz[0]);
            chk("cmp_nwait1", nwait1, exp_nw[1]);
            chk("cmp_busy1",  busy1,  exp_bz[1]);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic bus_idle();
        nm1 = 1'b1; nmreq = 1'b1; niorq = 1'b1; nrd = 1'b1; nwr = 1'b1;
    endtask

    initial begin
        reset = 1'b1; wait_en = 1'b1; nextwait = 2'b11; ext_en = 2'b11;
        bus_idle();
        nm1 = 1'b0; nmreq = 1'b0; nrd = 1'b0;
        tick(1);
        check_en = 1'b1;
        tick(1);
        chk("rst_nwait0", nwait0, 1'b1);
        chk("rst_busy0",  busy0,  1'b0);
        chk("rst_nwait1", nwait1, 1'b1);

        // M1 fetch straight out of reset
        reset = 1'b0;
        tick(1);
        chk("m1_low_k",   nwait0, 1'b0);
        chk("m1_busy_k",  busy0,  1'b1);
        tick(1);
        chk("m1_high_k1", nwait0, 1'b1);
        chk("m1_idle_k1", busy0,  1'b0);
        chk("m1b_low_k1", nwait1, 1'b0);
        tick(3);
        chk("m1_noretrig0", nwait0, 1'b1);
        chk("m1_noretrig1", nwait1, 1'b1);
        bus_idle();
        tick(2);

        // I/O read, then a second I/O cycle, then INTA
        nm1 = 1'b1; niorq = 1'b0; nrd = 1'b0;
        tick(3);
        chk("io_low_k2", nwait0, 1'b0);
        tick(1);
        chk("io_rel_k3", nwait0, 1'b1);
        niorq = 1'b1; nrd = 1'b1;
        tick(1);
        niorq = 1'b0; nrd = 1'b0;
        tick(3);
        chk("io2_low_k2", nwait0, 1'b0);
        tick(1);
        chk("io2_rel_k3", nwait0, 1'b1);
        tick(5);
        bus_idle();
        tick(2);
        nm1 = 1'b0; niorq = 1'b0;
        tick(3);
        chk("inta_nwait0", nwait0, 1'b1);
        chk("inta_nwait1", nwait1, 1'b1);
        bus_idle();
        tick(2);

        // MEM read (0 waits on dut0, 2 on dut1), then wait_en=0 M1
        nmreq = 1'b0; nrd = 1'b0;
        tick(1);
        chk("mem_nowait0", nwait0, 1'b1);
        chk("mem_wait1",   nwait1, 1'b0);
        tick(3);
        bus_idle();
        tick(2);
        wait_en = 1'b0;
        nm1 = 1'b0; nmreq = 1'b0; nrd = 1'b0;
        tick(1);
        chk("wen0_nwait0", nwait0, 1'b1);
        chk("wen0_nwait1", nwait1, 1'b1);
        tick(2);
        bus_idle();
        wait_en = 1'b1;
        tick(2);

        // External channels with masking
        ext_en = 2'b10; nextwait = 2'b10;
        tick(2);
        chk("ext_masked", nwait0, 1'b1);
        nextwait = 2'b01;
        tick(1);
        chk("ext_low_1", nwait0, 1'b0);
        tick(3);
        chk("ext_low_4", nwait0, 1'b0);
        nextwait = 2'b11;
        tick(1);
        chk("ext_rel", nwait0, 1'b1);
        tick(1);

        // M1 overlapping an external wait
        ext_en = 2'b11; nextwait = 2'b10;
        nm1 = 1'b0; nmreq = 1'b0; nrd = 1'b0;
        tick(1);
        chk("ov_busy_k",  busy0,  1'b1);
        chk("ov_low_k",   nwait0, 1'b0);
        tick(1);
        chk("ov_busy_k1", busy0,  1'b0);
        chk("ov_low_k1",  nwait0, 1'b0);
        tick(2);
        chk("ov_low_k3",  nwait0, 1'b0);
        nextwait = 2'b11;
        tick(1);
        chk("ov_rel_k4",  nwait0, 1'b1);
        bus_idle();
        tick(2);

        // wait_en dropped mid-count: count of 7 still completes
        nm1 = 1'b1; niorq = 1'b0; nrd = 1'b0;
        tick(1);
        wait_en = 1'b0;
        tick(6);
        chk("wen_mid_low_k6", nwait1, 1'b0);
        tick(1);
        chk("wen_mid_rel_k7", nwait1, 1'b1);
        wait_en = 1'b1;
        bus_idle();
        tick(2);

        // Abort by dropping strobes after two clocks
        nm1 = 1'b1; niorq = 1'b0; nwr = 1'b0;
        tick(2);
        chk("ab_low0", nwait0, 1'b0);
        chk("ab_low1", nwait1, 1'b0);
        niorq = 1'b1; nwr = 1'b1;
        tick(1);
        chk("ab_rel0",  nwait0, 1'b1);
        chk("ab_rel1",  nwait1, 1'b1);
        chk("ab_busy1", busy1,  1'b0);
        tick(2);

        // Reset pulse mid-count, strobes held through and after it
        niorq = 1'b0; nwr = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(1);
        chk("rp_nwait1", nwait1, 1'b1);
        chk("rp_busy1",  busy1,  1'b0);
        chk("rp_nwait0", nwait0, 1'b1);
        reset = 1'b0;
        tick(1);
        chk("rp_restart1", nwait1, 1'b0);
        bus_idle();
        tick(8);

        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
